// File: rtl/sbus_arbiter.sv
// sbus_arbiter: merges the data-side (dbus) and instruction-side (ibus) masters
// onto a single sbus slave. Holds a grant while the slave stalls, steers read
// data and address errors back to the owning master, and forces ibus priority
// after STARVE_LIMIT consecutive lost cycles.
// Optional build macro SBUS_ARB_STATS_EN adds saturating grant/conflict counters.
module sbus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // data-side master
  input  logic        dbus_en,
  input  logic        dbus_we,
  input  logic [1:0]  dbus_size,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data_w,
  output logic [31:0] dbus_data_r,
  output logic        dbus_stall,
  // instruction-side master
  input  logic        ibus_en,
  input  logic        ibus_we,
  input  logic [1:0]  ibus_size,
  input  logic [31:0] ibus_addr,
  input  logic [31:0] ibus_data_w,
  output logic [31:0] ibus_data_r,
  output logic        ibus_stall,
  // downstream slave
  output logic        sbus_o_en,
  output logic        sbus_o_we,
  output logic [1:0]  sbus_o_size,
  output logic [31:0] sbus_o_addr,
  output logic [31:0] sbus_o_data_w,
  input  logic [31:0] sbus_o_data_r,
  input  logic        sbus_o_stall,
  // address errors
  input  logic        s_error_adel,
  input  logic        s_error_ades,
  input  logic [31:0] s_error_addr,
  output logic        d_error_adel,
  output logic        d_error_ades,
  output logic [31:0] d_error_addr,
  output logic        i_error_adel,
  output logic        i_error_ades,
  output logic [31:0] i_error_addr
`ifdef SBUS_ARB_STATS_EN
  ,
  output logic [31:0] stat_dgrant,
  output logic [31:0] stat_igrant,
  output logic [31:0] stat_conflict
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK_D = 2'd1, LOCK_I = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_D = 2'd1, OWN_I = 2'd2} owner_t;

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  state_t      state_r, state_nxt_s;
  owner_t      grant_s, owner_r, owner_nxt_s;
  logic [3:0]  starve_cnt_r, starve_nxt_s;
  logic        d_acc_s, i_acc_s;

  // Pick the current grant: locked master, else dbus unless ibus is starving.
  always_comb begin
    grant_s = OWN_NONE;
    if (rst) begin
      grant_s = OWN_NONE;
    end else begin
      case (state_r)
        LOCK_D: grant_s = OWN_D;
        LOCK_I: grant_s = OWN_I;
        IDLE: begin
          if (dbus_en && !(ibus_en && (starve_cnt_r == LIMIT_C))) begin
            grant_s = OWN_D;
          end else if (ibus_en) begin
            grant_s = OWN_I;
          end else begin
            grant_s = OWN_NONE;
          end
        end
        default: grant_s = OWN_NONE;
      endcase
    end
  end

  // Drive the slave from the granted master; stall losers; gate errors by grant.
  always_comb begin
    sbus_o_en     = 1'b0;
    sbus_o_we     = 1'b0;
    sbus_o_size   = 2'd0;
    sbus_o_addr   = 32'h0;
    sbus_o_data_w = 32'h0;
    dbus_stall    = 1'b0;
    ibus_stall    = 1'b0;
    d_error_adel  = 1'b0;
    d_error_ades  = 1'b0;
    i_error_adel  = 1'b0;
    i_error_ades  = 1'b0;
    if (rst) begin
      sbus_o_en = 1'b0;
    end else begin
      case (grant_s)
        OWN_D: begin
          sbus_o_en     = dbus_en;
          sbus_o_we     = dbus_we;
          sbus_o_size   = dbus_size;
          sbus_o_addr   = dbus_addr;
          sbus_o_data_w = dbus_data_w;
        end
        OWN_I: begin
          sbus_o_en     = ibus_en;
          sbus_o_we     = ibus_we;
          sbus_o_size   = ibus_size;
          sbus_o_addr   = ibus_addr;
          sbus_o_data_w = ibus_data_w;
        end
        default: sbus_o_en = 1'b0;
      endcase
      dbus_stall   = dbus_en & ((grant_s == OWN_D) ? sbus_o_stall : 1'b1);
      ibus_stall   = ibus_en & ((grant_s == OWN_I) ? sbus_o_stall : 1'b1);
      d_error_adel = s_error_adel & (grant_s == OWN_D);
      d_error_ades = s_error_ades & (grant_s == OWN_D);
      i_error_adel = s_error_adel & (grant_s == OWN_I);
      i_error_ades = s_error_ades & (grant_s == OWN_I);
    end
  end

  assign d_error_addr = s_error_addr;
  assign i_error_addr = s_error_addr;
  assign d_acc_s      = dbus_en & ~dbus_stall;
  assign i_acc_s      = ibus_en & ~ibus_stall;

  // Next grant state, starvation count and response owner.
  always_comb begin
    state_nxt_s  = IDLE;
    starve_nxt_s = starve_cnt_r;
    owner_nxt_s  = OWN_NONE;
    case (state_r)
      IDLE: begin
        if ((grant_s == OWN_D) && sbus_o_stall) begin
          state_nxt_s = LOCK_D;
        end else if ((grant_s == OWN_I) && sbus_o_stall) begin
          state_nxt_s = LOCK_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK_D:  state_nxt_s = sbus_o_stall ? LOCK_D : IDLE;
      LOCK_I:  state_nxt_s = sbus_o_stall ? LOCK_I : IDLE;
      default: state_nxt_s = IDLE;
    endcase
    if (i_acc_s) begin
      starve_nxt_s = 4'd0;
    end else if (ibus_en && (starve_cnt_r < LIMIT_C)) begin
      starve_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
    if (d_acc_s) begin
      owner_nxt_s = OWN_D;
    end else if (i_acc_s) begin
      owner_nxt_s = OWN_I;
    end else begin
      owner_nxt_s = OWN_NONE;
    end
  end

  // State registers; reset aborts any lock and drops an in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
      owner_r      <= OWN_NONE;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_nxt_s;
      owner_r      <= owner_nxt_s;
    end
  end

  // Return read data to the owner of the previous cycle's acceptance only.
  always_comb begin
    dbus_data_r = 32'h0;
    ibus_data_r = 32'h0;
    if (rst) begin
      dbus_data_r = 32'h0;
    end else begin
      dbus_data_r = (owner_r == OWN_D) ? sbus_o_data_r : 32'h0;
      ibus_data_r = (owner_r == OWN_I) ? sbus_o_data_r : 32'h0;
    end
  end

`ifdef SBUS_ARB_STATS_EN
  // Saturating grant and conflict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dgrant   <= 32'h0;
      stat_igrant   <= 32'h0;
      stat_conflict <= 32'h0;
    end else begin
      if (d_acc_s && (stat_dgrant != 32'hFFFF_FFFF)) begin
        stat_dgrant <= stat_dgrant + 32'd1;
      end
      if (i_acc_s && (stat_igrant != 32'hFFFF_FFFF)) begin
        stat_igrant <= stat_igrant + 32'd1;
      end
      if (dbus_en && ibus_en && (stat_conflict != 32'hFFFF_FFFF)) begin
        stat_conflict <= stat_conflict + 32'd1;
      end
    end
  end
`endif

endmodule
